// File: rtl/stepper_pkg.sv
// Shared encodings for the stepper controller: modes, FSM states, coil table
// and the phase-advance rule.
package stepper_pkg;

  localparam logic [1:0] MODE_WAVE = 2'd0;
  localparam logic [1:0] MODE_FULL = 2'd1;
  localparam logic [1:0] MODE_HALF = 2'd2;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  function automatic logic [3:0] coil_pattern(input logic [2:0] ph);
    logic [3:0] pat;
    pat = 4'b0000;
    case (ph)
      3'd0: pat = 4'b0001;
      3'd1: pat = 4'b0011;
      3'd2: pat = 4'b0010;
      3'd3: pat = 4'b0110;
      3'd4: pat = 4'b0100;
      3'd5: pat = 4'b1100;
      3'd6: pat = 4'b1000;
      3'd7: pat = 4'b1001;
      default: pat = 4'b0000;
    endcase
    return pat;
  endfunction

  // An index of the wrong parity for the mode moves by one, landing on a legal one.
  function automatic logic [2:0] next_phase(input logic [2:0] ph, input logic [1:0] mode,
                                            input logic dir);
    logic [2:0] delta;
    case (mode)
      MODE_HALF: delta = 3'd1;
      MODE_FULL: delta = ph[0] ? 3'd2 : 3'd1;
      default:   delta = ph[0] ? 3'd1 : 3'd2;
    endcase
    return dir ? ph + delta : ph - delta;
  endfunction

endpackage

// File: rtl/stepper_ctrl_step_tick_gen.sv
// Step-rate divider: counts enabled cycles and fires a one-cycle tick once the
// count reaches the programmed period.
module step_tick_gen #(
  parameter int DIV_W = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             run_en,
  input  logic [DIV_W-1:0] period,
  output logic             step_tick
);

  logic [DIV_W-1:0] cnt;

  // >= so a period lowered below the current count fires at once
  assign step_tick = run_en && (cnt >= period);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run_en) begin
      cnt <= step_tick ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/stepper_ctrl.sv
// Unipolar 4-coil stepper driver: counted or continuous moves in wave, full or
// half-step sequencing, with a clock-enable step timer.
module stepper_ctrl
  import stepper_pkg::*;
#(
  parameter int DIV_W = 27,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] period,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             enable,
  input  logic             hold,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] steps,
  output logic [3:0]       coils,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left
);

  state_t     state;
  logic [2:0] ph;
  logic [2:0] ph_next;
  logic       continuous;
  logic       step_tick;

  assign ph_next = next_phase(ph, mode, dir);

  step_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (state == ST_IDLE),
    .run_en    ((state == ST_RUN) && enable),
    .period    (period),
    .step_tick (step_tick)
  );

  // stop takes priority over both start and a pending step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ph         <= 3'd0;
      continuous <= 1'b0;
      coils      <= 4'b0000;
      busy       <= 1'b0;
      done       <= 1'b0;
      steps_left <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            state      <= ST_RUN;
            busy       <= 1'b1;
            steps_left <= steps;
            continuous <= (steps == '0);
          end else if (!hold) begin
            coils <= 4'b0000;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            if (!hold) coils <= 4'b0000;
          end else if (step_tick) begin
            ph    <= ph_next;
            coils <= coil_pattern(ph_next);
            if (!continuous) begin
              steps_left <= steps_left - CNT_W'(1);
              if (steps_left == CNT_W'(1)) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_ctrl.sv
// Self-checking bench for stepper_ctrl: directed scenarios plus randomized moves
// compared cycle by cycle against a behavioural model of the motor controller.
module tb_stepper_ctrl;

  localparam int DIV_W = 27;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [DIV_W-1:0] period = '0;
  logic [1:0]       mode = 2'd0;
  logic             dir = 1'b1;
  logic             enable = 1'b1;
  logic             hold = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [CNT_W-1:0] steps = '0;
  logic [3:0]       coils;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] steps_left;

  int checks = 0;
  int errors = 0;

  stepper_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .period(period), .mode(mode), .dir(dir),
    .enable(enable), .hold(hold), .start(start), .stop(stop), .steps(steps),
    .coils(coils), .busy(busy), .done(done), .steps_left(steps_left)
  );

  always #5 clk = ~clk;

  logic [3:0] pat [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                          4'b0100, 4'b1100, 4'b1000, 4'b1001};

  // Behavioural model: motor position, enabled cycles since last step, move progress
  int         m_ph, m_cnt, m_left;
  bit         m_busy, m_cont, m_done;
  logic [3:0] m_coils;

  task automatic model_reset();
    m_ph = 0; m_cnt = 0; m_left = 0; m_busy = 0; m_cont = 0; m_done = 0; m_coils = 4'b0000;
  endtask

  task automatic model_edge();
    int d;
    m_done = 0;
    if (!m_busy) begin
      if (start && !stop) begin
        m_busy = 1; m_left = int'(steps); m_cont = (steps == 0); m_cnt = 0;
      end else if (!hold) m_coils = 4'b0000;
    end else if (stop) begin
      m_busy = 0;
      if (!hold) m_coils = 4'b0000;
    end else if (enable) begin
      if (m_cnt >= int'(period)) begin
        if (mode == 2'd2) d = 1;
        else if (mode == 2'd1) d = (m_ph % 2 == 1) ? 2 : 1;
        else d = (m_ph % 2 == 0) ? 2 : 1;
        m_ph = (m_ph + (dir ? d : 8 - d)) % 8;
        m_coils = pat[m_ph];
        m_cnt = 0;
        if (!m_cont) begin
          m_left--;
          if (m_left == 0) begin m_busy = 0; m_done = 1; end
        end
      end else m_cnt++;
    end
  endtask

  function automatic logic [CNT_W+5:0] exp_vec();
    return {m_coils, m_busy, m_done, CNT_W'(m_left)};
  endfunction

  wire [CNT_W+5:0] dut_vec = {coils, busy, done, steps_left};

  task automatic clk_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    hold = 1'b1;
    #1;
    model_reset();
    checks++; if (coils !== 4'b0000) begin errors++; $display("[TB] FAIL reset_coils: got %b expected 0000", coils); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (steps_left !== '0) begin errors++; $display("[TB] FAIL reset_left: got %0d expected 0", steps_left); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      clk_edge();
      checks++;
      if (dut_vec !== '0) begin
        errors++; $display("[TB] FAIL idle_quiet k=%0d: got %h expected 0", k, dut_vec);
      end
    end
  endtask

  task automatic test_half_fwd();
    logic [3:0] exp_seq [5] = '{4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100};
    logic [3:0] seen [5];
    int         at [5];
    int         n = 0, dones = 0;
    logic [3:0] prev;
    mode = 2'd2; dir = 1'b1; period = DIV_W'(3); steps = CNT_W'(5); enable = 1'b1; hold = 1'b1;
    prev = coils;
    start = 1'b1; clk_edge(); start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      clk_edge();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("[TB] FAIL half_fwd k=%0d: got %h expected %h", k, dut_vec, exp_vec());
      end
      if (coils !== prev && n < 5) begin seen[n] = coils; at[n] = k; n++; end
      if (done === 1'b1) dones++;
      prev = coils;
    end
    checks++; if (n != 5) begin errors++; $display("[TB] FAIL half_fwd_count: got %0d changes expected 5", n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (seen[i] !== exp_seq[i] || at[i] != 4 * (i + 1)) begin
        errors++; $display("[TB] FAIL half_fwd_step%0d: got %b at %0d expected %b at %0d", i, seen[i], at[i], exp_seq[i], 4 * (i + 1));
      end
    end
    checks++; if (dones != 1) begin errors++; $display("[TB] FAIL half_fwd_done: got %0d pulses expected 1", dones); end
    checks++; if (busy !== 1'b0 || steps_left !== '0) begin errors++; $display("[TB] FAIL half_fwd_end: got busy=%b left=%0d expected 0 0", busy, steps_left); end
  endtask

  task automatic test_full_rev();
    logic [3:0] exp_seq [3] = '{4'b1001, 4'b1100, 4'b0110};
    logic [3:0] seen [3];
    logic [3:0] prev;
    int         n = 0;
    pulse_reset();
    mode = 2'd1; dir = 1'b0; period = DIV_W'(1); steps = CNT_W'(3);
    prev = coils;
    start = 1'b1; clk_edge(); start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      clk_edge();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("[TB] FAIL full_rev k=%0d: got %h expected %h", k, dut_vec, exp_vec());
      end
      if (coils !== prev && n < 3) begin seen[n] = coils; n++; end
      prev = coils;
    end
    checks++;
    if (n != 3 || seen[0] !== exp_seq[0] || seen[1] !== exp_seq[1] || seen[2] !== exp_seq[2]) begin
      errors++; $display("[TB] FAIL full_rev_seq: got %0d changes %b %b %b expected 1001 1100 0110", n, seen[0], seen[1], seen[2]);
    end
  endtask

  task automatic test_pause_stop();
    logic [3:0] snap;
    int         first = 0;
    mode = 2'd0; dir = 1'b1; period = DIV_W'(9); steps = '0; hold = 1'b1; enable = 1'b1;
    start = 1'b1; clk_edge(); start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      clk_edge();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("[TB] FAIL pause_run k=%0d: got %h expected %h", k, dut_vec, exp_vec()); end
    end
    enable = 1'b0; snap = coils;
    for (int k = 1; k <= 25; k++) begin
      clk_edge();
      checks++;
      if (coils !== snap || dut_vec !== exp_vec()) begin errors++; $display("[TB] FAIL pause_frozen k=%0d: got %h expected %h", k, dut_vec, exp_vec()); end
    end
    enable = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      clk_edge();
      if (coils !== snap && first == 0) first = k;
    end
    checks++; if (first != 5) begin errors++; $display("[TB] FAIL pause_resume: got step at %0d expected 5", first); end
    stop = 1'b1; snap = coils; clk_edge(); stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || coils !== snap) begin
      errors++; $display("[TB] FAIL stop: got busy=%b done=%b coils=%b expected 0 0 %b", busy, done, coils, snap);
    end
    hold = 1'b0; clk_edge();
    checks++; if (coils !== 4'b0000) begin errors++; $display("[TB] FAIL hold_off: got %b expected 0000", coils); end
  endtask

  task automatic test_edge_cases();
    int old_ph;
    hold = 1'b1;
    start = 1'b1; stop = 1'b1; steps = CNT_W'(4); clk_edge(); start = 1'b0; stop = 1'b0;
    checks++; if (busy !== 1'b0 || dut_vec !== exp_vec()) begin errors++; $display("[TB] FAIL start_stop_idle: got busy=%b expected 0", busy); end
    mode = 2'd2; period = DIV_W'(5); steps = CNT_W'(10);
    start = 1'b1; clk_edge(); start = 1'b0;
    clk_edge(); clk_edge();
    start = 1'b1; steps = CNT_W'(3); clk_edge(); start = 1'b0;
    checks++;
    if (steps_left !== CNT_W'(10) || busy !== 1'b1) begin
      errors++; $display("[TB] FAIL start_busy: got left=%0d busy=%b expected 10 1", steps_left, busy);
    end
    stop = 1'b1; clk_edge(); stop = 1'b0;
    period = DIV_W'(100); steps = '0;
    start = 1'b1; clk_edge(); start = 1'b0;
    for (int k = 0; k < 50; k++) clk_edge();
    old_ph = m_ph;
    period = DIV_W'(2); clk_edge();
    checks++;
    if (coils !== pat[(old_ph + 1) % 8] || dut_vec !== exp_vec()) begin
      errors++; $display("[TB] FAIL period_lower: got %b expected %b", coils, pat[(old_ph + 1) % 8]);
    end
    for (int k = 0; k < 3; k++) clk_edge();
    rst_n = 1'b0; #1; model_reset();
    checks++;
    if (coils !== 4'b0000 || busy !== 1'b0 || steps_left !== '0) begin
      errors++; $display("[TB] FAIL reset_mid: got coils=%b busy=%b left=%0d expected 0000 0 0", coils, busy, steps_left);
    end
    #2; rst_n = 1'b1;
  endtask

  task automatic test_random();
    int  stop_at, k;
    for (int it = 0; it < 12; it++) begin
      mode = 2'($urandom_range(0, 3)); dir = 1'($urandom_range(0, 1));
      period = DIV_W'($urandom_range(0, 4)); steps = CNT_W'($urandom_range(0, 6));
      hold = 1'($urandom_range(0, 1)); enable = 1'b1;
      stop_at = (steps == 0 || $urandom_range(0, 3) == 0) ? int'($urandom_range(3, 50)) : 1000;
      start = 1'b1; clk_edge(); start = 1'b0;
      k = 0;
      while (m_busy && k < 400) begin
        k++;
        enable = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) begin mode = 2'($urandom_range(0, 3)); dir = 1'($urandom_range(0, 1)); end
        stop = (k == stop_at);
        clk_edge();
        stop = 1'b0;
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++; $display("[TB] FAIL random it=%0d k=%0d: got %h expected %h", it, k, dut_vec, exp_vec());
        end
      end
      if (m_busy) begin
        checks++; errors++; $display("[TB] FAIL random_timeout it=%0d: got busy after %0d cycles expected idle", it, k);
        stop = 1'b1; clk_edge(); stop = 1'b0;
      end
      for (int j = 0; j < 2; j++) begin
        clk_edge();
        checks++;
        if (dut_vec !== exp_vec()) begin errors++; $display("[TB] FAIL random_idle it=%0d: got %h expected %h", it, dut_vec, exp_vec()); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_half_fwd();
    test_full_rev();
    test_pause_stop();
    test_edge_cases();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
